uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter between NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Each transfer is followed by a fixed idle gap, and a watchdog aborts a transfer whose tx_done never arrives.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 16384,
   localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [7:0]           uart_tx_data,
   output logic                 uart_tx_ready,
   input  logic                 uart_tx_done
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int CW    = ID_W + 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
   localparam logic [CW-1:0]    CAND_N   = CW'(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [WD_W-1:0]    r_wdog;
   logic [GAP_W-1:0]   r_gap;
   logic               r_done_q;
   logic [NUM_REQ-1:0] r_ack;
   logic [ID_W-1:0]    r_grant_id;
   logic               r_busy;
   logic               r_timeout_err;
   logic [7:0]         r_tx_data;
   logic               r_tx_ready;

   state_t             w_state_nxt;
   logic [ID_W-1:0]    w_ptr_nxt;
   logic [WD_W-1:0]    w_wdog_nxt;
   logic [GAP_W-1:0]   w_gap_nxt;
   logic [NUM_REQ-1:0] w_ack_nxt;
   logic [ID_W-1:0]    w_grant_id_nxt;
   logic               w_busy_nxt;
   logic               w_timeout_err_nxt;
   logic [7:0]         w_tx_data_nxt;
   logic               w_tx_ready_nxt;

   logic               w_found;
   logic [ID_W-1:0]    w_winner;
   logic [CW-1:0]      w_cand;
   logic               w_done_rise;
   logic [ID_W-1:0]    w_ptr_after;
   logic [7:0]         w_win_byte;

   assign w_done_rise = uart_tx_done & ~r_done_q;
   assign w_win_byte  = req_data[8*int'(w_winner) +: 8];
   assign w_ptr_after = (w_winner == ID_LAST) ? '0 : w_winner + ID_W'(1);

   // Round-robin search: first asserted request at or above r_ptr, wrapping past the top index.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_ptr} + CW'(k);
         if (w_cand >= CAND_N) begin
            w_cand = w_cand - CAND_N;
         end else begin
            w_cand = w_cand;
         end
         if (!w_found && req[w_cand[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_cand[ID_W-1:0];
         end else begin
            w_found  = w_found;
         end
      end
   end

   // Next-state and next-output logic for the grant / send / gap sequence.
   always_comb begin
      w_state_nxt       = r_state;
      w_ptr_nxt         = r_ptr;
      w_wdog_nxt        = r_wdog;
      w_gap_nxt         = r_gap;
      w_ack_nxt         = '0;
      w_grant_id_nxt    = r_grant_id;
      w_timeout_err_nxt = r_timeout_err;
      w_tx_data_nxt     = r_tx_data;
      w_tx_ready_nxt    = r_tx_ready;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_tx_data_nxt            = w_win_byte;
               w_tx_ready_nxt           = 1'b1;
               w_ack_nxt[w_winner]      = 1'b1;
               w_grant_id_nxt           = w_winner;
               w_ptr_nxt                = w_ptr_after;
               w_wdog_nxt               = '0;
               w_state_nxt              = S_SEND;
            end else begin
               w_tx_ready_nxt = 1'b0;
            end
         end
         S_SEND: begin
            // A completion edge wins over a watchdog expiry landing on the same cycle.
            if (w_done_rise) begin
               w_tx_ready_nxt = 1'b0;
               w_gap_nxt      = '0;
               w_state_nxt    = S_GAP;
            end else if (r_wdog == WD_LAST) begin
               w_timeout_err_nxt = 1'b1;
               w_tx_ready_nxt    = 1'b0;
               w_gap_nxt         = '0;
               w_state_nxt       = S_GAP;
            end else begin
               w_wdog_nxt = r_wdog + WD_W'(1);
            end
         end
         S_GAP: begin
            w_tx_ready_nxt = 1'b0;
            if (r_gap == GAP_LAST) begin
               w_gap_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap + GAP_W'(1);
            end
         end
         default: begin
            w_tx_ready_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State, counters and registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_wdog        <= '0;
         r_gap         <= '0;
         r_done_q      <= 1'b0;
         r_ack         <= '0;
         r_grant_id    <= '0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_tx_data     <= 8'h00;
         r_tx_ready    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_wdog        <= w_wdog_nxt;
         r_gap         <= w_gap_nxt;
         r_done_q      <= uart_tx_done;
         r_ack         <= w_ack_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_busy        <= w_busy_nxt;
         r_timeout_err <= w_timeout_err_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_tx_ready    <= w_tx_ready_nxt;
      end
   end

   assign ack           = r_ack;
   assign grant_id      = r_grant_id;
   assign busy          = r_busy;
   assign timeout_err   = r_timeout_err;
   assign uart_tx_data  = r_tx_data;
   assign uart_tx_ready = r_tx_ready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized requester/UART stub phase.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int GP = 2;
   localparam int TO = 16384;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   ack;
   logic [1:0]     grant_id;
   logic           busy;
   logic           timeout_err;
   logic [7:0]     uart_tx_data;
   logic           uart_tx_ready;
   logic           uart_tx_done;

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
      .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready), .uart_tx_done(uart_tx_done)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase 0 idle, 1 sending, 2 gap
   int         m_phase, m_ptr, m_wd, m_gap;
   bit         m_done_prev;
   logic [N-1:0] e_ack;
   logic [1:0] e_gid;
   logic       e_busy, e_err, e_ready;
   logic [7:0] e_data;
   logic [7:0] exp_bytes[$];

   // stimulus state
   int         req_mode;
   bit         auto_uart;
   bit         stub_active;
   int         stub_wait;
   int         ack_log[$];
   int         ack_cnt[N];
   logic [7:0] byte_log[$];

   function automatic int pick_winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   task automatic model_step();
      int w;
      if (reset) begin
         m_phase = 0; m_ptr = 0; m_wd = 0; m_gap = 0; m_done_prev = 1'b0;
         e_ack = '0; e_gid = 2'd0; e_busy = 1'b0; e_err = 1'b0; e_data = 8'h00; e_ready = 1'b0;
         return;
      end
      e_ack = '0;
      if (m_phase == 0) begin
         if (req != '0) begin
            w = pick_winner(req, m_ptr);
            e_ack[w] = 1'b1;
            e_gid    = 2'(w);
            e_data   = req_data[8*w +: 8];
            e_ready  = 1'b1;
            m_ptr    = (w + 1) % N;
            m_wd     = 0;
            m_phase  = 1;
            exp_bytes.push_back(e_data);
         end
      end else if (m_phase == 1) begin
         if (uart_tx_done && !m_done_prev) begin
            e_ready = 1'b0; m_phase = 2; m_gap = GP;
         end else if (m_wd == TO - 1) begin
            e_err = 1'b1; e_ready = 1'b0; m_phase = 2; m_gap = GP;
         end else begin
            m_wd++;
         end
      end else begin
         m_gap--;
         if (m_gap == 0) m_phase = 0;
      end
      e_busy      = (m_phase != 0);
      m_done_prev = uart_tx_done;
   endtask

   task automatic check_cycle();
      n_tests++;
      if (ack !== e_ack || grant_id !== e_gid || busy !== e_busy || timeout_err !== e_err ||
          uart_tx_data !== e_data || uart_tx_ready !== e_ready) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL cycle@%0t got/exp: ack %b/%b gid %0d/%0d busy %b/%b err %b/%b data %h/%h ready %b/%b",
                     $time, ack, e_ack, grant_id, e_gid, busy, e_busy, timeout_err, e_err,
                     uart_tx_data, e_data, uart_tx_ready, e_ready);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic uart_stub();
      if (uart_tx_ready) begin
         if (!stub_active) begin
            stub_active  = 1'b1;
            stub_wait    = $urandom_range(0, 6);
            byte_log.push_back(uart_tx_data);
            uart_tx_done = 1'b0;
         end else if (stub_wait > 0) begin
            stub_wait--;
            uart_tx_done = 1'b0;
         end else begin
            uart_tx_done = 1'b1;
         end
      end else begin
         stub_active  = 1'b0;
         uart_tx_done = ($urandom_range(0, 7) == 0);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         case (req_mode)
            0: if (ack[i]) req[i] = 1'b0;
            2: begin
               if (ack[i]) begin
                  if ($urandom_range(0, 1) == 1) req_data[8*i +: 8] = 8'($urandom);
                  else req[i] = 1'b0;
               end else if (!req[i]) begin
                  if ($urandom_range(0, 3) == 0) begin
                     req[i] = 1'b1;
                     req_data[8*i +: 8] = 8'($urandom);
                  end
               end else if ($urandom_range(0, 63) == 0) begin
                  req[i] = 1'b0;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      model_step();
      @(negedge clock);
      check_cycle();
      for (int i = 0; i < N; i++) begin
         if (ack[i] === 1'b1) begin
            ack_log.push_back(i);
            ack_cnt[i]++;
         end
      end
      if (auto_uart) uart_stub();
      drive_reqs();
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; uart_tx_done = 1'b0; auto_uart = 1'b0; req_mode = 0;
      cycle();
      cycle();
      reset = 1'b0;
      ack_log.delete(); byte_log.delete(); exp_bytes.delete();
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      stub_active = 1'b0;
   endtask

   task automatic run_until_acks(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (ack_log.size() < n && c < budget) begin
         cycle();
         c++;
      end
      check_val(name, (ack_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      logic [7:0] adam[4];
      int cnt;
      int c;
      adam[0] = 8'h41; adam[1] = 8'h44; adam[2] = 8'h41; adam[3] = 8'h4D;
      req_data = '0;

      // reset values
      do_reset();
      check_val("rst_ack", 32'(ack), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ready", 32'(uart_tx_ready), 32'd0);
      check_val("rst_data", 32'(uart_tx_data), 32'd0);

      // 1: single byte, one-cycle latency, two-cycle gap
      req = 4'b0001; req_data = 32'h0000_0041;
      cycle();
      check_val("t1_ack", 32'(ack), 32'd1);
      check_val("t1_ready", 32'(uart_tx_ready), 32'd1);
      check_val("t1_data", 32'(uart_tx_data), 32'h41);
      repeat (3) cycle();
      uart_tx_done = 1'b1;
      cycle();
      check_val("t1_ready_drop", 32'(uart_tx_ready), 32'd0);
      check_val("t1_gap1_busy", 32'(busy), 32'd1);
      uart_tx_done = 1'b0;
      cycle();
      check_val("t1_gap2_busy", 32'(busy), 32'd1);
      cycle();
      check_val("t1_idle_busy", 32'(busy), 32'd0);

      // 2: four simultaneous requests served in order, spelling ADAM
      do_reset();
      auto_uart = 1'b1;
      req = 4'b1111; req_data = 32'h4D41_4441;
      run_until_acks("t2_budget", 4, 300);
      for (int i = 0; i < 4; i++) begin
         check_val("t2_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF, 32'(i));
         check_val("t2_ack_once", 32'(ack_cnt[i]), 32'd1);
         check_val("t2_byte", (i < byte_log.size()) ? 32'(byte_log[i]) : 32'hFFFF, 32'(adam[i]));
      end

      // 3: two continuous requesters alternate
      do_reset();
      auto_uart = 1'b1; req_mode = 1;
      req = 4'b0101; req_data = 32'h0033_0011;
      run_until_acks("t3_budget", 4, 300);
      for (int i = 0; i < 4; i++)
         check_val("t3_seq", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF, (i % 2 == 0) ? 32'd0 : 32'd2);

      // 4: watchdog abort, then a later request still served
      do_reset();
      req = 4'b0001; req_data = 32'h0000_0077;
      cycle();
      cnt = 1;
      c = 0;
      while (uart_tx_ready === 1'b1 && c < 20000) begin
         cycle();
         c++;
         if (uart_tx_ready === 1'b1) cnt++;
      end
      check_val("t4_send_len", 32'(cnt), 32'(TO));
      check_val("t4_err", 32'(timeout_err), 32'd1);
      check_val("t4_ready", 32'(uart_tx_ready), 32'd0);
      c = 0;
      while (busy !== 1'b0 && c < 50) begin
         cycle();
         c++;
      end
      check_val("t4_idle", 32'(busy), 32'd0);
      req = 4'b0010; req_data = 32'h0000_5A00;
      run_until_acks("t4_req1_budget", 2, 20);
      check_val("t4_req1", (ack_log.size() >= 2) ? 32'(ack_log[1]) : 32'hFFFF, 32'd1);
      check_val("t4_sticky", 32'(timeout_err), 32'd1);

      // 5: reset mid-SEND
      repeat (3) cycle();
      reset = 1'b1; req = 4'b1000; req_data = 32'h6600_0000;
      cycle();
      check_val("t5_ready", 32'(uart_tx_ready), 32'd0);
      check_val("t5_busy", 32'(busy), 32'd0);
      check_val("t5_ack", 32'(ack), 32'd0);
      check_val("t5_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;
      cycle();
      check_val("t5_ack3", 32'(ack), 32'h8);
      check_val("t5_gid", 32'(grant_id), 32'd3);

      // 6: tx_done already high at SEND entry does not complete
      do_reset();
      uart_tx_done = 1'b1;
      cycle();
      req = 4'b0001; req_data = 32'h0000_0055;
      cycle();
      repeat (5) cycle();
      check_val("t6_hold", 32'(uart_tx_ready), 32'd1);
      uart_tx_done = 1'b0;
      cycle();
      check_val("t6_low", 32'(uart_tx_ready), 32'd1);
      uart_tx_done = 1'b1;
      cycle();
      check_val("t6_rise", 32'(uart_tx_ready), 32'd0);
      uart_tx_done = 1'b0;

      // 7: randomized traffic against the model, then byte scoreboard
      do_reset();
      auto_uart = 1'b1; req_mode = 2;
      repeat (6000) cycle();
      req_mode = 0; req = '0;
      repeat (100) cycle();
      check_val("t7_count", 32'(byte_log.size()), 32'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size(); i++) begin
         if (i < byte_log.size()) check_val("t7_byte", 32'(byte_log[i]), 32'(exp_bytes[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
